// File: rtl/clk_div_pkg.sv
// rtl/clk_div_pkg.sv - shared constants and helpers for the clock divider bank
//
// Purpose : mode encodings, default widths/terminal count, and the wrap-time
//           div_out selection shared by every divider channel.
// Ports   : none (package).

package clk_div_pkg;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_PULSE  = 1'b1;

    localparam int          CNT_W      = 24;
    localparam int unsigned DEFAULT_TC = 266664;

    // Value div_out takes at a wrap edge.
    // A disable still finishes the outgoing wrap in the outgoing mode; the
    // output is forced low only from the next cycle on.
    // A mode change restarts the waveform: low for square, high (tracking
    // the tick of this wrap) for pulse.
    function automatic logic wrap_div(
        input logic cur_mode,
        input logic cur_div,
        input logic apply,
        input logic new_mode,
        input logic new_en
    );
        logic res;
        if (apply && new_en && (new_mode != cur_mode)) begin
            res = (new_mode == MODE_PULSE);
        end else if (cur_mode == MODE_SQUARE) begin
            res = ~cur_div;
        end else begin
            res = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// rtl/clk_div_channel.sv - one programmable divider channel with shadowed config
//
// Purpose : counts 0..tc, emits a one-cycle tick per wrap and a square or
//           pulse div_out. Config writes land in shadow registers and are
//           moved to the active set only at a wrap or sync (or immediately
//           when the channel is idle), so the outputs never glitch.
// Ports   :
//   clk      in   system clock
//   rst_n    in   synchronous active-low reset
//   cfg_we   in   accepted config transfer addressed to this channel
//   cfg_tc   in   new terminal count
//   cfg_mode in   new mode (square / pulse)
//   cfg_en   in   new enable
//   sync     in   restart counter in phase with the other channels
//   pending  out  shadow config waiting for the next wrap/sync
//   tick     out  one-cycle strobe per wrap
//   div_out  out  divided output

module clk_div_channel
    import clk_div_pkg::*;
#(
    parameter int              CNT_W  = 24,
    parameter logic [CNT_W-1:0] RST_TC = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cfg_we,
    input  logic [CNT_W-1:0] cfg_tc,
    input  logic             cfg_mode,
    input  logic             cfg_en,
    input  logic             sync,
    output logic             pending,
    output logic             tick,
    output logic             div_out
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] tc_q;
    logic             mode_q;
    logic             en_q;
    logic [CNT_W-1:0] sh_tc;
    logic             sh_mode;
    logic             sh_en;
    logic             at_tc;

    assign at_tc = (cnt == tc_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt     <= '0;
            tc_q    <= RST_TC;
            mode_q  <= MODE_SQUARE;
            en_q    <= 1'b1;
            sh_tc   <= RST_TC;
            sh_mode <= MODE_SQUARE;
            sh_en   <= 1'b1;
            pending <= 1'b0;
            tick    <= 1'b0;
            div_out <= 1'b0;
        end else if (!en_q) begin
            // Idle channel: nothing to glitch, so a config applies at once
            // and counting restarts from 0 on the following edge.
            cnt     <= '0;
            tick    <= 1'b0;
            div_out <= 1'b0;
            if (cfg_we) begin
                tc_q    <= cfg_tc;
                mode_q  <= cfg_mode;
                en_q    <= cfg_en;
                sh_tc   <= cfg_tc;
                sh_mode <= cfg_mode;
                sh_en   <= cfg_en;
            end
        end else begin
            if (sync || at_tc) begin
                cnt <= '0;
                if (pending) begin
                    tc_q    <= sh_tc;
                    mode_q  <= sh_mode;
                    en_q    <= sh_en;
                    pending <= 1'b0;
                end
                // sync beats a coincident wrap: no tick, waveform restarts low.
                if (sync) begin
                    tick    <= 1'b0;
                    div_out <= 1'b0;
                end else begin
                    tick    <= 1'b1;
                    div_out <= wrap_div(mode_q, div_out, pending, sh_mode, sh_en);
                end
            end else begin
                cnt     <= cnt + CNT_W'(1);
                tick    <= 1'b0;
                div_out <= (mode_q == MODE_PULSE) ? 1'b0 : div_out;
            end
            // Only accepted while not pending, so this never collides with
            // the clear above; an accept on a wrap edge waits for the next wrap.
            if (cfg_we) begin
                sh_tc   <= cfg_tc;
                sh_mode <= cfg_mode;
                sh_en   <= cfg_en;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// rtl/clk_div_bank.sv - bank of NUM_CH independent programmable clock dividers
//
// Purpose : decodes the shared valid/ready config port onto the channels,
//           muxes per-channel readiness back to cfg_ready and fans out sync.
// Ports   :
//   clk       in   system clock
//   rst_n     in   synchronous active-low reset
//   cfg_valid in   config request
//   cfg_ready out  selected channel has no pending config (combinational)
//   cfg_ch    in   target channel
//   cfg_tc    in   new terminal count
//   cfg_mode  in   0 square, 1 pulse
//   cfg_en    in   channel enable
//   sync      in   restart all enabled channels in phase
//   tick      out  per-channel one-cycle wrap strobe
//   div_out   out  per-channel divided output

module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH     = 4,
    parameter int          CNT_W      = clk_div_pkg::CNT_W,
    parameter int unsigned DEFAULT_TC = clk_div_pkg::DEFAULT_TC,
    parameter int          CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CNT_W-1:0]  cfg_tc,
    input  logic              cfg_mode,
    input  logic              cfg_en,
    input  logic              sync,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] div_out
);

    logic [NUM_CH-1:0] pending;
    logic [NUM_CH-1:0] cfg_we;

    // Out-of-range channel numbers (NUM_CH not a power of two) are never ready.
    always_comb begin
        cfg_ready = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    always_comb begin
        cfg_we = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_we[i] = cfg_valid && cfg_ready && (cfg_ch == CH_W'(i));
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .CNT_W  (CNT_W),
            .RST_TC (CNT_W'(DEFAULT_TC))
        ) u_ch (
            .clk      (clk),
            .rst_n    (rst_n),
            .cfg_we   (cfg_we[g]),
            .cfg_tc   (cfg_tc),
            .cfg_mode (cfg_mode),
            .cfg_en   (cfg_en),
            .sync     (sync),
            .pending  (pending[g]),
            .tick     (tick[g]),
            .div_out  (div_out[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// tb/tb_clk_div_bank.sv - self-checking bench for clk_div_bank

module tb_clk_div_bank;

    logic       clk;
    logic       rst_n;
    logic       cfg_valid;
    logic       cfg_ready;
    logic       cfg_ch;
    logic [7:0] cfg_tc;
    logic       cfg_mode;
    logic       cfg_en;
    logic       sync;
    logic [1:0] tick;
    logic [1:0] div_out;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    typedef struct {
        logic [1:0] tick;
        logic [1:0] div;
    } exp_t;

    exp_t sb[$];

    clk_div_bank #(
        .NUM_CH     (2),
        .CNT_W      (8),
        .DEFAULT_TC (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_tc    (cfg_tc),
        .cfg_mode  (cfg_mode),
        .cfg_en    (cfg_en),
        .sync      (sync),
        .tick      (tick),
        .div_out   (div_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Closed-form expectation j edges after the counter was last at 0 with
    // div_out = d0: returns {tick, div_out}.
    function automatic logic [1:0] expc(input int j, input int tc, input bit mode, input bit d0);
        logic tk;
        logic dv;
        int   w;
        tk = ((j % (tc + 1)) == 0);
        w  = j / (tc + 1);
        dv = mode ? tk : (d0 ^ w[0]);
        return {tk, dv};
    endfunction

    task automatic push(input logic [1:0] c0, input logic [1:0] c1);
        exp_t e;
        e.tick = {c1[1], c0[1]};
        e.div  = {c1[0], c0[0]};
        sb.push_back(e);
    endtask

    task automatic edge_chk();
        exp_t e;
        @(posedge clk);
        #1;
        cyc++;
        total++;
        assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL scoreboard_empty cycle=%0d obs=empty exp=entry", cyc);
        end
        if (sb.size() != 0) begin
            e = sb.pop_front();
            total++;
            assert (tick === e.tick) else begin
                bad++;
                $error("FAIL tick cycle=%0d obs=%b exp=%b", cyc, tick, e.tick);
            end
            total++;
            assert (div_out === e.div) else begin
                bad++;
                $error("FAIL div_out cycle=%0d obs=%b exp=%b", cyc, div_out, e.div);
            end
        end
    endtask

    task automatic chk_ready(input logic ch, input logic expv, input string tag);
        cfg_ch = ch;
        #1;
        total++;
        assert (cfg_ready === expv) else begin
            bad++;
            $error("FAIL %s cycle=%0d obs=%b exp=%b", tag, cyc, cfg_ready, expv);
        end
    endtask

    task automatic cfg(input logic ch, input logic [7:0] tc, input logic m, input logic e);
        cfg_valid = 1'b1;
        cfg_ch    = ch;
        cfg_tc    = tc;
        cfg_mode  = m;
        cfg_en    = e;
    endtask

    task automatic sync_edge();
        cfg_valid = 1'b0;
        sync      = 1'b1;
        push(2'b00, 2'b00);
        edge_chk();
        sync = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        cfg_ch    = 1'b0;
        cfg_tc    = 8'd0;
        cfg_mode  = 1'b0;
        cfg_en    = 1'b1;
        sync      = 1'b0;

        // reset state
        push(2'b00, 2'b00);
        edge_chk();
        push(2'b00, 2'b00);
        edge_chk();
        chk_ready(1'b0, 1'b1, "rst_ready");

        // defaults: tc=4, square
        rst_n = 1'b1;
        for (int j = 1; j <= 20; j++) begin
            push(expc(j, 4, 0, 0), expc(j, 4, 0, 0));
            edge_chk();
        end

        // queue tc=9 on both channels, then sync applies them
        cfg(1'b0, 8'd9, 1'b0, 1'b1);
        chk_ready(1'b0, 1'b1, "ready_ch0_free");
        push(expc(21, 4, 0, 0), expc(21, 4, 0, 0));
        edge_chk();
        chk_ready(1'b0, 1'b0, "ready_ch0_pending");
        cfg(1'b1, 8'd9, 1'b0, 1'b1);
        chk_ready(1'b1, 1'b1, "ready_ch1_free");
        push(expc(22, 4, 0, 0), expc(22, 4, 0, 0));
        edge_chk();
        sync_edge();
        chk_ready(1'b0, 1'b1, "sync_apply_ch0");
        chk_ready(1'b1, 1'b1, "sync_apply_ch1");

        // retune ch0 to tc=3 at count 2; old period holds until the wrap
        for (int j = 1; j <= 22; j++) begin
            cfg_valid = 1'b0;
            if (j == 3) cfg(1'b0, 8'd3, 1'b0, 1'b1);
            push((j <= 10) ? expc(j, 9, 0, 0) : expc(j - 10, 3, 0, 1), expc(j, 9, 0, 0));
            edge_chk();
            cfg_valid = 1'b0;
            if (j == 3 || j == 9) chk_ready(1'b0, 1'b0, "retune_busy");
            if (j == 5) chk_ready(1'b1, 1'b1, "retune_ch1_free");
            if (j == 10) chk_ready(1'b0, 1'b1, "retune_done");
        end
        sync_edge();

        // back-pressure on ch1: second request waits for the wrap
        for (int j = 1; j <= 21; j++) begin
            cfg_valid = 1'b0;
            if (j == 1) cfg(1'b1, 8'd4, 1'b0, 1'b1);
            else if (j <= 11) cfg(1'b1, 8'd2, 1'b0, 1'b1);
            if (j >= 2 && j <= 10) begin
                if (j == 5) chk_ready(1'b0, 1'b1, "bp_ch0_free");
                chk_ready(1'b1, 1'b0, "bp_hold");
            end
            if (j == 11) chk_ready(1'b1, 1'b1, "bp_release");
            push(expc(j, 3, 0, 0),
                 (j <= 10) ? expc(j, 9, 0, 0) :
                 (j <= 15) ? expc(j - 10, 4, 0, 1) : expc(j - 15, 2, 0, 0));
            edge_chk();
        end
        sync_edge();

        // ch0: pulse mode tc=2, then disable, then re-enable tc=1 square
        for (int j = 1; j <= 20; j++) begin
            logic [1:0] c0;
            cfg_valid = 1'b0;
            if (j == 1)  cfg(1'b0, 8'd2, 1'b1, 1'b1);
            if (j == 8)  cfg(1'b0, 8'd2, 1'b1, 1'b0);
            if (j == 14) cfg(1'b0, 8'd1, 1'b0, 1'b1);
            if (j < 4)        c0 = 2'b00;
            else if (j == 4)  c0 = 2'b11;
            else if (j <= 10) c0 = (((j - 4) % 3) == 0) ? 2'b11 : 2'b00;
            else if (j <= 14) c0 = 2'b00;
            else              c0 = expc(j - 14, 1, 0, 0);
            push(c0, expc(j, 2, 0, 0));
            edge_chk();
            cfg_valid = 1'b0;
            if (j == 8)  chk_ready(1'b0, 1'b0, "disable_pending");
            if (j == 12) chk_ready(1'b0, 1'b1, "disable_applied");
            if (j == 14) chk_ready(1'b0, 1'b1, "enable_no_pending");
        end

        // accept on ch1's wrap edge stays pending; sync collides with ch0 wrap
        cfg(1'b1, 8'd5, 1'b0, 1'b1);
        push(expc(7, 1, 0, 0), expc(21, 2, 0, 0));
        edge_chk();
        cfg_valid = 1'b0;
        chk_ready(1'b1, 1'b0, "wrap_accept_pending");
        sync_edge();
        chk_ready(1'b1, 1'b1, "sync_cleared_pending");
        for (int j = 1; j <= 14; j++) begin
            cfg_valid = 1'b0;
            if (j == 13) cfg(1'b0, 8'd0, 1'b1, 1'b1);
            if (j == 14) cfg(1'b1, 8'd0, 1'b0, 1'b1);
            push((j == 14) ? 2'b11 : expc(j, 1, 0, 0), expc(j, 5, 0, 0));
            edge_chk();
        end
        sync_edge();

        // tc=0: ch0 pulse held high, ch1 square toggles every cycle
        for (int j = 1; j <= 8; j++) begin
            cfg_valid = 1'b0;
            if (j == 8) cfg(1'b1, 8'd7, 1'b0, 1'b1);
            push(2'b11, expc(j, 0, 0, 0));
            edge_chk();
        end

        // reset mid-run with ch1 pending and a request on ch0 in flight
        rst_n = 1'b0;
        cfg(1'b0, 8'd2, 1'b0, 1'b1);
        push(2'b00, 2'b00);
        edge_chk();
        cfg_valid = 1'b0;
        chk_ready(1'b0, 1'b1, "rst_pend_ch0");
        chk_ready(1'b1, 1'b1, "rst_pend_ch1");
        rst_n = 1'b1;
        for (int j = 1; j <= 10; j++) begin
            push(expc(j, 4, 0, 0), expc(j, 4, 0, 0));
            edge_chk();
        end

        total++;
        assert (sb.size() == 0) else begin
            bad++;
            $error("FAIL scoreboard_leftover obs=%0d exp=0", sb.size());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
